// File: rtl/regbank_wb_arbiter.sv
// Write-back arbiter for the register bank's single write port.
// Round-robin selection among NUMREQ producers over valid/ready. The
// winner lands in a one-entry output register that drives the bank.
// An external stall lets another agent own the write port.
// Build option: define RB_WB_ARB_FIXED_PRIO_EN for fixed priority
// (index 0 highest, no rotating pointer). Round-robin is the default.
`timescale 1ns/1ps

module regbank_wb_arbiter #(
  parameter int NUMREQ    = 3,
  parameter int NUMREGS   = 32,
  parameter int DATAWIDTH = 32,
  localparam int AW       = $clog2(NUMREGS),
  localparam int IW       = $clog2(NUMREQ)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NUMREQ-1:0]           req_valid_i,
  output logic [NUMREQ-1:0]           req_ready_o,
  input  logic [NUMREQ*AW-1:0]        req_addr_i,
  input  logic [NUMREQ*DATAWIDTH-1:0] req_data_i,
  input  logic                        wb_stall_i,
  output logic                        we_o,
  output logic [AW-1:0]               waddr_o,
  output logic [DATAWIDTH-1:0]        wdata_o,
  output logic [IW-1:0]               grant_idx_o
);

  logic                 out_valid_q, out_valid_d;
  logic [AW-1:0]        out_addr_q, out_addr_d;
  logic [DATAWIDTH-1:0] out_data_q, out_data_d;
  logic [IW-1:0]        out_idx_q, out_idx_d;

  logic                 can_accept;
  logic                 xfer;
  logic [NUMREQ-1:0]    ready;
  logic [IW-1:0]        win_idx;
  logic [AW-1:0]        win_addr;
  logic [DATAWIDTH-1:0] win_data;
  logic [IW-1:0]        scan_base;
  logic [IW:0]          scan_sum;
  logic [IW-1:0]        scan_idx;

`ifdef RB_WB_ARB_FIXED_PRIO_EN
  assign scan_base = '0;
`else
  logic [IW-1:0] ptr_q, ptr_d;
  assign scan_base = ptr_q;
`endif

  // A held entry blocks new acceptances only while the port is stalled.
  assign can_accept = !out_valid_q || !wb_stall_i;

  // Scan requesters starting at scan_base and grant the first valid one.
  // Ready is forced low while reset is asserted so nothing is handshaken
  // into a register that is being cleared.
  always_comb begin
    ready    = '0;
    xfer     = 1'b0;
    win_idx  = '0;
    scan_sum = '0;
    scan_idx = '0;
    if (rst_ni && can_accept) begin
      for (int i = 0; i < NUMREQ; i++) begin
        scan_sum = {1'b0, scan_base} + (IW+1)'(i);
        if (scan_sum >= (IW+1)'(NUMREQ)) begin
          scan_sum = scan_sum - (IW+1)'(NUMREQ);
        end
        scan_idx = scan_sum[IW-1:0];
        if (!xfer && req_valid_i[scan_idx]) begin
          xfer           = 1'b1;
          ready[scan_idx] = 1'b1;
          win_idx        = scan_idx;
        end
      end
    end
  end

  // Mux the winner's address and data using the one-hot ready vector.
  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int j = 0; j < NUMREQ; j++) begin
      if (ready[j]) begin
        win_addr = req_addr_i[j*AW +: AW];
        win_data = req_data_i[j*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  // Output register next state: load on transfer, drain when unstalled.
  always_comb begin
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_addr_d  = win_addr;
      out_data_d  = win_data;
      out_idx_d   = win_idx;
    end else if (!wb_stall_i) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
    end
  end

`ifndef RB_WB_ARB_FIXED_PRIO_EN
  // Round-robin pointer moves to the slot after the most recent winner.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = (win_idx == IW'(NUMREQ-1)) ? '0 : win_idx + 1'b1;
    end
  end

  // Round-robin pointer state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Writes to x0 consume a slot but never reach the bank.
  assign we_o        = out_valid_q && !wb_stall_i && (out_addr_q != '0);
  assign waddr_o     = out_addr_q;
  assign wdata_o     = out_data_q;
  assign grant_idx_o = out_idx_q;
  assign req_ready_o = ready;

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Scoreboard bench for regbank_wb_arbiter with a queue-based reference model.
`timescale 1ns/1ps

module tb_regbank_wb_arbiter;
  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_ni = 1'b0;
  logic [N-1:0]    req_valid_i = '0;
  logic [N-1:0]    req_ready_o;
  logic [N*AW-1:0] req_addr_i = '0;
  logic [N*DW-1:0] req_data_i = '0;
  logic            wb_stall_i = 1'b0;
  logic            we_o;
  logic [AW-1:0]   waddr_o;
  logic [DW-1:0]   wdata_o;
  logic [IW-1:0]   grant_idx_o;

  regbank_wb_arbiter #(.NUMREQ(N), .NUMREGS(32), .DATAWIDTH(DW)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .wb_stall_i(wb_stall_i),
    .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
    .grant_idx_o(grant_idx_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  ready;
    logic          we;
    logic [IW-1:0] idx;
    logic [AW-1:0] addr;
  } cyc_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [IW-1:0] idx;
  } wr_t;

  cyc_t cq[$];
  wr_t  wq[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: an optional pending write plus the rotation start.
  bit   m_pend = 0;
  int   m_ptr = 0;
  wr_t  m_cur = '{addr: '0, data: '0, idx: '0};

  logic [AW-1:0] s_addr[N];
  logic [DW-1:0] s_data[N];

  task automatic rand_req(input int zero_pct);
    for (int k = 0; k < N; k++) begin
      if ($urandom_range(99) < zero_pct) s_addr[k] = '0;
      else s_addr[k] = AW'($urandom_range(31, 1));
      s_data[k] = $urandom;
    end
  endtask

  task automatic step(input logic rst_v, input logic [N-1:0] v, input logic stall);
    cyc_t c;
    int   win;
    int   start;
    @(negedge clk);
    rst_ni = rst_v;
    req_valid_i = v;
    wb_stall_i = stall;
    for (int k = 0; k < N; k++) begin
      req_addr_i[k*AW +: AW] = s_addr[k];
      req_data_i[k*DW +: DW] = s_data[k];
    end
    c.ready = '0;
    c.we = 1'b0;
    c.idx = '0;
    c.addr = '0;
    if (!rst_v) begin
      m_pend = 0;
      m_ptr = 0;
      m_cur = '{addr: '0, data: '0, idx: '0};
      cq.push_back(c);
      return;
    end
    c.we = m_pend && !stall && (m_cur.addr != 0);
    c.idx = m_cur.idx;
    c.addr = m_cur.addr;
    if (c.we) wq.push_back(m_cur);
`ifdef RB_WB_ARB_FIXED_PRIO_EN
    start = 0;
`else
    start = m_ptr;
`endif
    win = -1;
    if (!m_pend || !stall) begin
      for (int off = 0; off < N; off++) begin
        int k;
        k = (start + off) % N;
        if (win < 0 && v[k]) win = k;
      end
    end
    if (win >= 0) begin
      c.ready[win] = 1'b1;
      m_cur = '{addr: s_addr[win], data: s_data[win], idx: IW'(win)};
      m_pend = 1;
      m_ptr = (win + 1) % N;
    end else if (!stall) begin
      m_pend = 0;
    end
    cq.push_back(c);
  endtask

  // Monitor: compare each cycle's outputs and every bank write.
  initial begin
    cyc_t c;
    wr_t  w;
    forever begin
      @(negedge clk);
      #2;
      if (cq.size() > 0) begin
        c = cq.pop_front();
        vectors++;
        if (req_ready_o !== c.ready) begin
          miscompares++;
          $display("FAIL ready t=%0t got %b exp %b", $time, req_ready_o, c.ready);
        end
        vectors++;
        if (we_o !== c.we) begin
          miscompares++;
          $display("FAIL we t=%0t got %b exp %b", $time, we_o, c.we);
        end
        vectors++;
        if (grant_idx_o !== c.idx) begin
          miscompares++;
          $display("FAIL grant_idx t=%0t got %0d exp %0d", $time, grant_idx_o, c.idx);
        end
        vectors++;
        if (waddr_o !== c.addr) begin
          miscompares++;
          $display("FAIL waddr t=%0t got %0d exp %0d", $time, waddr_o, c.addr);
        end
      end
      if (we_o === 1'b1) begin
        vectors++;
        if (wq.size() == 0) begin
          miscompares++;
          $display("FAIL write t=%0t got unexpected write addr %0d exp none", $time, waddr_o);
        end else begin
          w = wq.pop_front();
          if (waddr_o !== w.addr || wdata_o !== w.data || grant_idx_o !== w.idx) begin
            miscompares++;
            $display("FAIL write t=%0t got a=%0d d=%h i=%0d exp a=%0d d=%h i=%0d",
                     $time, waddr_o, wdata_o, grant_idx_o, w.addr, w.data, w.idx);
          end
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < N; k++) begin
      s_addr[k] = '0;
      s_data[k] = '0;
    end
    // Reset with requests present: no ready, no write.
    rand_req(0);
    step(1'b0, 3'b111, 1'b0);
    step(1'b0, 3'b111, 1'b0);

    // Single requester.
    s_addr[1] = 5'd5;
    s_data[1] = 32'hDEADBEEF;
    step(1'b1, 3'b010, 1'b0);
    step(1'b1, 3'b000, 1'b0);
    step(1'b1, 3'b000, 1'b0);

    // Round-robin from reset with everyone requesting.
    step(1'b0, 3'b000, 1'b0);
    for (int i = 0; i < 6; i++) begin
      rand_req(0);
      step(1'b1, 3'b111, 1'b0);
    end
    step(1'b1, 3'b000, 1'b0);

    // Pending entry held across a three-cycle stall.
    rand_req(0);
    s_addr[0] = 5'd7;
    step(1'b1, 3'b001, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 3'b111, 1'b1);
    step(1'b1, 3'b111, 1'b0);
    step(1'b1, 3'b000, 1'b0);

    // x0 request consumes the grant and advances the pointer.
    step(1'b0, 3'b000, 1'b0);
    rand_req(0);
    s_addr[0] = 5'd0;
    s_data[0] = 32'h1234;
    step(1'b1, 3'b001, 1'b0);
    rand_req(0);
    step(1'b1, 3'b111, 1'b0);
    step(1'b1, 3'b000, 1'b0);

    // Stall with an empty output still admits one entry.
    rand_req(0);
    step(1'b1, 3'b111, 1'b1);
    step(1'b1, 3'b111, 1'b1);
    step(1'b1, 3'b111, 1'b0);
    step(1'b1, 3'b000, 1'b0);

    // Reset during a stalled pending write discards it.
    rand_req(0);
    step(1'b1, 3'b100, 1'b0);
    step(1'b1, 3'b111, 1'b1);
    step(1'b0, 3'b111, 1'b1);
    step(1'b1, 3'b000, 1'b0);
    step(1'b1, 3'b000, 1'b0);

    // Requesters 0 and 2 continuously valid.
    for (int i = 0; i < 5; i++) begin
      rand_req(0);
      step(1'b1, 3'b101, 1'b0);
    end

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      rand_req(12);
      step(($urandom_range(59) != 0), N'($urandom_range(7)), ($urandom_range(3) == 0));
    end
    step(1'b1, 3'b000, 1'b0);
    step(1'b1, 3'b000, 1'b0);

    @(negedge clk);
    #5;
    vectors++;
    if (wq.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d writes outstanding exp 0", wq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
